// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad digit entry sequencer for the alarm-clock datapath
// Ports:
//   clock, reset (async, active-low) ; one_second (1-cycle tick per second)
//   time_button, alarm_button (levels) ; alarm_sel (slot for show/commit)
//   key (keypad code, NOKEY when idle)
//   shift, show_new_time, show_a, show_sel, load_new_a (one-hot),
//   load_new_c, reset_count, digit_count, entry_error (1-cycle abort pulse)
module keypad_entry_ctrl #(
  parameter int KEY_W     = 4,
  parameter int NOKEY     = 10,
  parameter int DIGITS    = 4,
  parameter int TIMEOUT_S = 10,
  parameter int ALARMS    = 2,
  parameter int SLOT_W    = 1,
  parameter int CNT_W     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              one_second,
  input  logic              time_button,
  input  logic              alarm_button,
  input  logic [SLOT_W-1:0] alarm_sel,
  input  logic [KEY_W-1:0]  key,
  output logic              shift,
  output logic              show_new_time,
  output logic              show_a,
  output logic [SLOT_W-1:0] show_sel,
  output logic [ALARMS-1:0] load_new_a,
  output logic              load_new_c,
  output logic              reset_count,
  output logic [CNT_W-1:0]  digit_count,
  output logic              entry_error
);
  localparam int SEC_W = $clog2(TIMEOUT_S);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DIGITS);
  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;
  state_t state, state_next;
  logic [SEC_W-1:0] sec_cnt;
  logic err_next, cap_sel, dc_inc;
  logic valid, key_up, sel_bad, no_digits, timeout, timing;
  assign valid     = key <= KEY_W'(9);
  // only the true idle code releases a held key; other invalid codes keep it "held"
  assign key_up    = key == KEY_W'(NOKEY);
  assign sel_bad   = 32'(alarm_sel) >= 32'(ALARMS);
  assign no_digits = digit_count == '0;
  assign timing    = state == KEY_WAITED || state == KEY_ENTRY;
  assign timeout   = one_second && sec_cnt == SEC_LAST;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= SHOW_TIME;
      sec_cnt     <= '0;
      digit_count <= '0;
      show_sel    <= '0;
      entry_error <= 1'b0;
    end else begin
      state       <= state_next;
      // any state change restarts the timeout window, dropping a coincident tick
      sec_cnt     <= (!timing || state_next != state) ? '0 : sec_cnt + SEC_W'(one_second);
      digit_count <= state_next == SHOW_TIME ? '0 :
                     dc_inc ? (digit_count == DMAX ? DMAX : digit_count + 1'b1) : digit_count;
      show_sel    <= cap_sel ? alarm_sel : show_sel;
      entry_error <= err_next;
    end
  end
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    cap_sel    = 1'b0;
    dc_inc     = 1'b0;
    case (state)
      SHOW_TIME:
        if (alarm_button) begin
          err_next   = sel_bad;
          cap_sel    = !sel_bad;
          state_next = sel_bad ? SHOW_TIME : SHOW_ALARM;
        end else if (valid) begin
          state_next = KEY_STORED;
          dc_inc     = 1'b1;
        end
      SHOW_ALARM: state_next = alarm_button ? SHOW_ALARM : SHOW_TIME;
      KEY_STORED: state_next = KEY_WAITED;
      KEY_WAITED:
        if (key_up) state_next = KEY_ENTRY;
        else if (timeout) begin
          state_next = SHOW_TIME;
          err_next   = 1'b1;
        end
      KEY_ENTRY:
        if (alarm_button) begin
          err_next   = no_digits || sel_bad;
          cap_sel    = !(no_digits || sel_bad);
          state_next = (no_digits || sel_bad) ? SHOW_TIME : SET_ALARM_TIME;
        end else if (time_button) begin
          err_next   = no_digits;
          state_next = no_digits ? SHOW_TIME : SET_CURRENT_TIME;
        end else if (timeout) state_next = SHOW_TIME;
        else if (valid) begin
          state_next = KEY_STORED;
          dc_inc     = 1'b1;
        end
      default: state_next = SHOW_TIME;
    endcase
  end
  always_comb begin
    shift         = state == KEY_STORED;
    show_new_time = state == KEY_STORED || state == KEY_WAITED || state == KEY_ENTRY;
    show_a        = state == SHOW_ALARM;
    load_new_a    = state == SET_ALARM_TIME ? ALARMS'(1) << show_sel : '0;
    load_new_c    = state == SET_CURRENT_TIME;
    reset_count   = state == SET_CURRENT_TIME;
  end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: randomized scoreboard bench for keypad_entry_ctrl
module tb_keypad_entry_ctrl;
  localparam int KEY_W = 4, NOKEY = 10, DIGITS = 4, TIMEOUT_S = 10;
  localparam int ALARMS = 2, SLOT_W = 2, CNT_W = 3;
  logic clock = 1'b0, reset = 1'b0, one_second = 1'b0;
  logic time_button = 1'b0, alarm_button = 1'b0;
  logic [SLOT_W-1:0] alarm_sel = '0;
  logic [KEY_W-1:0] key = KEY_W'(NOKEY);
  logic shift, show_new_time, show_a, load_new_c, reset_count, entry_error;
  logic [SLOT_W-1:0] show_sel;
  logic [ALARMS-1:0] load_new_a;
  logic [CNT_W-1:0] digit_count;
  int checks = 0, passes = 0;
  typedef struct packed {
    logic sh; logic snt; logic lc; logic rc; logic [ALARMS-1:0] la; logic err; logic [CNT_W-1:0] dc;
  } ev_t;
  ev_t exp_q[$];
  keypad_entry_ctrl #(.KEY_W(KEY_W), .NOKEY(NOKEY), .DIGITS(DIGITS), .TIMEOUT_S(TIMEOUT_S),
                      .ALARMS(ALARMS), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .one_second(one_second), .time_button(time_button),
    .alarm_button(alarm_button), .alarm_sel(alarm_sel), .key(key), .shift(shift),
    .show_new_time(show_new_time), .show_a(show_a), .show_sel(show_sel),
    .load_new_a(load_new_a), .load_new_c(load_new_c), .reset_count(reset_count),
    .digit_count(digit_count), .entry_error(entry_error));
  always #5 clock = ~clock;
  function automatic int dcap(input int n);
    return n > DIGITS ? DIGITS : n;
  endfunction
  function automatic ev_t ev_shift(input int n);
    return '{sh: 1'b1, snt: 1'b1, lc: 1'b0, rc: 1'b0, la: '0, err: 1'b0, dc: CNT_W'(dcap(n))};
  endfunction
  function automatic ev_t ev_loadc(input int n);
    return '{sh: 1'b0, snt: 1'b0, lc: 1'b1, rc: 1'b1, la: '0, err: 1'b0, dc: CNT_W'(dcap(n))};
  endfunction
  function automatic ev_t ev_loada(input int sel, input int n);
    ev_t e = '0;
    e.la = ALARMS'(1 << sel);
    e.dc = CNT_W'(dcap(n));
    return e;
  endfunction
  function automatic ev_t ev_err();
    ev_t e = '0;
    e.err = 1'b1;
    return e;
  endfunction
  always @(negedge clock) begin
    ev_t got, e;
    got = {shift, show_new_time, load_new_c, reset_count, load_new_a, entry_error, digit_count};
    if (reset && (shift || load_new_c || reset_count || load_new_a != '0 || entry_error)) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL unexpected_event got=%h", got);
      else begin
        e = exp_q.pop_front();
        if (got == e) passes++;
        else $display("FAIL event got=%h exp=%h", got, e);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic pulse();
    one_second = 1'b1;
    cyc(1);
    one_second = 1'b0;
    cyc(1);
  endtask
  task automatic digit(input int i, input bit dwell);
    exp_q.push_back(ev_shift(i + 1));
    key = KEY_W'($urandom_range(0, 9));
    cyc($urandom_range(1, 4));
    if ($urandom_range(0, 1) == 1) begin
      key = KEY_W'($urandom_range(11, 15));
      cyc($urandom_range(1, 3));
    end
    key = KEY_W'(NOKEY);
    cyc(3);
    if ($urandom_range(0, 1) == 1) begin
      key = KEY_W'($urandom_range(11, 15));
      cyc(2);
      key = KEY_W'(NOKEY);
      cyc(1);
    end
    if (dwell) repeat ($urandom_range(0, TIMEOUT_S - 1)) pulse();
  endtask
  // kind: 0 commit time, 1 commit alarm, 2 entry timeout, 3 stuck key
  task automatic scn(input int kind, input int n, input int sel, input bit both);
    for (int i = 0; i < n - 1; i++) digit(i, 1'b1);
    if (kind == 3) begin
      exp_q.push_back(ev_shift(n));
      exp_q.push_back(ev_err());
      key = KEY_W'($urandom_range(0, 9));
      cyc(3);
      repeat (TIMEOUT_S - 1) pulse();
      one_second = 1'b1;
      cyc(1);
      one_second = 1'b0;
      key = KEY_W'(NOKEY);
      cyc(4);
      return;
    end
    digit(n - 1, kind < 2);
    if (kind == 0) begin
      exp_q.push_back(ev_loadc(n));
      time_button = 1'b1;
    end else if (kind == 1) begin
      exp_q.push_back(sel < ALARMS ? ev_loada(sel, n) : ev_err());
      alarm_sel = SLOT_W'(sel);
      alarm_button = 1'b1;
      time_button = both;
    end else begin
      repeat (TIMEOUT_S - 1) pulse();
      chk("timeout_early", {31'b0, show_new_time}, 1);
      one_second = 1'b1;
      cyc(1);
      one_second = 1'b0;
      chk("timeout_exit", {28'b0, show_new_time, digit_count}, 0);
    end
    cyc(1);
    time_button = 1'b0;
    alarm_button = 1'b0;
    cyc(4);
  endtask
  initial begin
    cyc(2);
    chk("reset_held", {shift, show_new_time, show_a, show_sel, load_new_a, load_new_c,
                       reset_count, digit_count, entry_error}, 0);
    reset = 1'b1;
    cyc(2);
    chk("reset_idle", {shift, show_new_time, show_a, show_sel, load_new_a, load_new_c,
                       reset_count, digit_count, entry_error}, 0);
    key = KEY_W'(12);
    cyc(4);
    chk("invalid_key_idle", {31'b0, show_new_time}, 0);
    key = KEY_W'(NOKEY);
    alarm_sel = 2'd1;
    alarm_button = 1'b1;
    cyc(2);
    chk("show_alarm", {29'b0, show_a, show_sel}, 3'b101);
    alarm_button = 1'b0;
    cyc(2);
    chk("show_alarm_exit", {31'b0, show_a}, 0);
    exp_q.push_back(ev_err());
    alarm_sel = 2'd3;
    alarm_button = 1'b1;
    cyc(1);
    alarm_button = 1'b0;
    cyc(3);
    chk("show_alarm_bad_sel", {31'b0, show_a}, 0);
    scn(0, 4, 0, 1'b0);
    scn(1, 4, 1, 1'b0);
    scn(1, 4, 2, 1'b0);
    scn(2, 1, 0, 1'b0);
    scn(3, 1, 0, 1'b0);
    scn(0, 6, 0, 1'b0);
    scn(1, 3, 0, 1'b1);
    digit(0, 1'b0);
    digit(1, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_reset", {28'b0, show_new_time, digit_count}, 0);
    cyc(2);
    reset = 1'b1;
    cyc(3);
    chk("after_reset_idle", {29'b0, show_new_time, load_new_c, entry_error}, 0);
    repeat (40) scn($urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    cyc(5);
    chk("queue_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Parametrised keypad/time-entry controller for the alarm-clock datapath; successor to the single-alarm fixed-timeout entry FSM.
- Sequences digit entry from the keypad and drives shift/load/display strobes into the key shift register, the alarm registers and the time counter.
- Adds configurable timeout and digit depth, multiple alarm slots, a digit counter, invalid-key filtering and an error strobe.

Parameters:
- KEY_W, 4, keypad code width.
- NOKEY, 10, code meaning "no key pressed".
- DIGITS, 4, digits per full entry; digit_count saturates here.
- TIMEOUT_S, 10, one_second pulses before an entry or stuck-key timeout (>=2).
- ALARMS, 2, number of alarm slots (>=1).
- SLOT_W, 1, width of alarm_sel/show_sel, >= clog2(ALARMS), minimum 1.
- CNT_W, 3, width of digit_count, >= clog2(DIGITS+1).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- one_second  input  1  one-cycle pulse once per second.
- time_button  input  1  level; commit entry as current time.
- alarm_button  input  1  level; show alarm / commit entry as alarm.
- alarm_sel  input  SLOT_W  alarm slot chosen for show/commit.
- key  input  KEY_W  keypad code; NOKEY when idle.
- shift  output  1  one cycle; shift key into entry register.
- show_new_time  output  1  display entry register.
- show_a  output  1  display alarm slot show_sel.
- show_sel  output  SLOT_W  registered slot for show_a/load_new_a.
- load_new_a  output  ALARMS  one-hot; load entry into that alarm slot.
- load_new_c  output  1  load entry into current time.
- reset_count  output  1  clear seconds prescaler (same cycle as load_new_c).
- digit_count  output  CNT_W  digits entered this entry.
- entry_error  output  1  one-cycle pulse on aborted entry.

Behaviour:
- Reset (reset=0, async): state SHOW_TIME, sec_cnt 0, digit_count 0, show_sel 0, entry_error 0; all strobes 0.
- Valid key: key<=9. Codes 10..2^KEY_W-1 (including NOKEY) are "no key" for transitions; in KEY_WAITED only key==NOKEY counts as release.
- States / transitions (registered next state, one cycle per transition):
  - SHOW_TIME: alarm_button -> SHOW_ALARM (capture show_sel<=alarm_sel); else valid key -> KEY_STORED (digit_count<=0 then +1, i.e. 1); else stay.
  - SHOW_ALARM: alarm_button held -> stay; else SHOW_TIME. Out-of-range alarm_sel (>=ALARMS) on entry -> stay in SHOW_TIME, pulse entry_error.
  - KEY_STORED: shift=1 for exactly this cycle -> KEY_WAITED.
  - KEY_WAITED: key==NOKEY -> KEY_ENTRY; else timeout -> SHOW_TIME with entry_error pulse (stuck key); else stay.
  - KEY_ENTRY, priority high to low:
    - alarm_button -> SET_ALARM_TIME (capture show_sel).
    - time_button -> SET_CURRENT_TIME.
    - timeout -> SHOW_TIME, no error.
    - valid key -> KEY_STORED, digit_count +1 saturating at DIGITS; shift still occurs past saturation.
    - else stay.
  - Commit guard: button with digit_count==0, or alarm_button with alarm_sel>=ALARMS -> SHOW_TIME and pulse entry_error instead of committing.
  - SET_ALARM_TIME: load_new_a[show_sel]=1 one cycle -> SHOW_TIME.
  - SET_CURRENT_TIME: load_new_c=reset_count=1 one cycle -> SHOW_TIME.
  - Unused encodings -> SHOW_TIME.
- digit_count clears on every SHOW_TIME entry; holds during KEY_WAITED/KEY_ENTRY.
- Timeout counter sec_cnt:
  - Counts one_second pulses only in KEY_WAITED or KEY_ENTRY; clears to 0 on any cycle where the state changes and in all other states.
  - timeout = one_second && sec_cnt==TIMEOUT_S-1, so the TIMEOUT_S-th pulse in the state causes the transition.
  - one_second in the same cycle as a state change is discarded.
- Outputs are Moore decodes of the registered state, except entry_error, which is registered and asserts the cycle after the aborting transition.
- show_new_time=1 in KEY_STORED, KEY_WAITED and KEY_ENTRY. show_a=1 in SHOW_ALARM.
- Simultaneous alarm_button and time_button: alarm wins.
- Reset mid-entry: immediate SHOW_TIME, nothing loaded.

Test Plan:
- Reset low then high, key=NOKEY -> SHOW_TIME; all outputs 0; digit_count=0.
- Keys 1,2,3,4 (each pressed 3 cycles then NOKEY) then time_button -> 4 single-cycle shift pulses; digit_count=4; one-cycle load_new_c with reset_count; back to SHOW_TIME.
- Same entry with alarm_sel=1 and alarm_button -> load_new_a=2'b10 for one cycle; alarm_sel=2 (ALARMS=2) -> no load, entry_error pulse.
- Enter one digit, then idle: 9 one_second pulses -> stays in KEY_ENTRY; 10th -> SHOW_TIME; digit_count=0; no error.
- Hold key=5 for 10 one_second pulses -> one shift, then SHOW_TIME with entry_error=1 for one cycle.
- key=12 in SHOW_TIME -> no transition. time_button in KEY_ENTRY with 6 digits keyed (DIGITS=4) -> 6 shifts, digit_count=4, load_new_c asserted.
